sequencer_step_engine: RTL

//  Downstream of the key encoder stage. Consumes edge-detected beat toggles, sequencer_on/play levels,
//  the tempo pulse and the synced key levels. Stores an NUM_BEATS x 8 note pattern, steps through it at
//  the selected tempo and drives the 8-bit note-enable vector for the oscillator/mixer stage.
//  In piano mode it passes live key levels straight through instead.

---
 rtl/sass_seq_pkg.sv | 23 ++
 rtl/sequencer_step_engine_beat_timer.sv | 57 +++++
 rtl/sequencer_step_engine.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sass_seq_pkg.sv
// Shared types and constants for the sequencer step engine: FSM state
// encoding, tempo table (ticks per beat at 10 kHz) and a tempo helper.
package sass_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAUSED = 2'd1,
        RUN    = 2'd2
    } seq_state_t;

    localparam int NUM_TEMPOS = 4;

    // 60, 90, 120 and 150 BPM at a 10 kHz tick
    localparam logic [13:0] TICKS_PER_BEAT [NUM_TEMPOS] = '{
        14'd10000, 14'd6667, 14'd5000, 14'd4000
    };

    // Tempo index advance; the 2-bit width gives the 3 -> 0 wrap for free
    function automatic logic [1:0] next_tempo(input logic [1:0] cur);
        return cur + 2'd1;
    endfunction

endpackage

// File: rtl/sequencer_step_engine_beat_timer.sv
// Beat timer: counts system ticks for the selected tempo, advances the beat
// index (wrapping at NUM_BEATS) and emits a one-cycle strobe per advance.
// 'clear' forces beat 0 / tick 0; 'run' low holds the position.
module beat_timer
    import sass_seq_pkg::*;
#(
    parameter int NUM_BEATS = 8,
    parameter int BEAT_W    = $clog2(NUM_BEATS)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              run,
    input  logic              clear,
    input  logic [1:0]        tempo_sel,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              beat_strobe
);

    logic [13:0]       tick_cnt_r;
    logic [BEAT_W-1:0] beat_idx_r;
    logic              beat_strobe_r;
    logic [13:0]       limit_s;

    // Last tick index of a beat at the current tempo; >= compare lets a
    // switch to a shorter tempo mid-beat force an immediate advance
    always_comb begin
        limit_s = TICKS_PER_BEAT[tempo_sel] - 14'd1;
    end

    // Tick counter, beat index and beat strobe
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tick_cnt_r    <= 14'd0;
            beat_idx_r    <= '0;
            beat_strobe_r <= 1'b0;
        end else if (clear) begin
            tick_cnt_r    <= 14'd0;
            beat_idx_r    <= '0;
            beat_strobe_r <= 1'b0;
        end else if (run) begin
            if (tick_cnt_r >= limit_s) begin
                tick_cnt_r    <= 14'd0;
                beat_idx_r    <= beat_idx_r + BEAT_W'(1);
                beat_strobe_r <= 1'b1;
            end else begin
                tick_cnt_r    <= tick_cnt_r + 14'd1;
                beat_strobe_r <= 1'b0;
            end
        end else begin
            beat_strobe_r <= 1'b0;
        end
    end

    assign beat_idx    = beat_idx_r;
    assign beat_strobe = beat_strobe_r;

endmodule

// File: rtl/sequencer_step_engine.sv
// Sequencer step engine: holds an NUM_BEATS x 8 note pattern, edits it from
// toggle pulses, steps through it at the selected tempo and drives the note
// enables (live keys in piano mode, pattern in run, silence when paused).
// Optional feature macro SEQ_BEAT_LED_EN adds a one-hot beat_led output.
module sequencer_step_engine
    import sass_seq_pkg::*;
#(
    parameter int NUM_BEATS = 8,
    parameter int TEMPO_RST = 2,
    parameter int BEAT_W    = $clog2(NUM_BEATS)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [7:0]           toggle,
    input  logic [7:0]           button_press,
    input  logic                 sequencer_on,
    input  logic                 play,
    input  logic                 tempo_button,
    output logic [7:0]           notes_out,
    output logic [7:0]           pattern_view,
    output logic [BEAT_W-1:0]    beat_idx,
    output logic                 beat_strobe,
`ifdef SEQ_BEAT_LED_EN
    output logic [NUM_BEATS-1:0] beat_led,
`endif
    output logic [1:0]           tempo_sel
);

    seq_state_t  state_r;
    seq_state_t  next_state_s;
    logic [1:0]  tempo_r;
    logic [7:0]  pattern_r [NUM_BEATS];
    logic [7:0]  edited_s;
    logic [7:0]  notes_next_s;
    logic [7:0]  notes_out_r;
    logic [7:0]  pattern_view_r;

    // Mode decode from the current input levels
    always_comb begin
        if (!sequencer_on) begin
            next_state_s = IDLE;
        end else if (play) begin
            next_state_s = RUN;
        end else begin
            next_state_s = PAUSED;
        end
    end

    // Current beat's pattern with this cycle's toggles applied (not in IDLE)
    always_comb begin
        if (state_r != IDLE) begin
            edited_s = pattern_r[beat_idx] ^ toggle;
        end else begin
            edited_s = pattern_r[beat_idx];
        end
    end

    // Note source select by mode
    always_comb begin
        case (state_r)
            IDLE:    notes_next_s = button_press;
            RUN:     notes_next_s = edited_s;
            PAUSED:  notes_next_s = 8'h00;
            default: notes_next_s = 8'h00;
        endcase
    end

    // State, tempo index, pattern storage and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r        <= IDLE;
            tempo_r        <= 2'(TEMPO_RST);
            notes_out_r    <= 8'h00;
            pattern_view_r <= 8'h00;
            for (int i = 0; i < NUM_BEATS; i++) begin
                pattern_r[i] <= 8'h00;
            end
        end else begin
            state_r             <= next_state_s;
            pattern_r[beat_idx] <= edited_s;
            pattern_view_r      <= edited_s;
            notes_out_r         <= notes_next_s;
            if (tempo_button) begin
                tempo_r <= next_tempo(tempo_r);
            end else begin
                tempo_r <= tempo_r;
            end
        end
    end

    beat_timer #(
        .NUM_BEATS (NUM_BEATS),
        .BEAT_W    (BEAT_W)
    ) u_beat_timer (
        .clk         (clk),
        .n_rst       (n_rst),
        .run         (state_r == RUN),
        .clear       (state_r == IDLE),
        .tempo_sel   (tempo_r),
        .beat_idx    (beat_idx),
        .beat_strobe (beat_strobe)
    );

`ifdef SEQ_BEAT_LED_EN
    logic [NUM_BEATS-1:0] beat_led_r;

    // One-hot beat indicator, dark in piano mode
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            beat_led_r <= '0;
        end else if (sequencer_on) begin
            beat_led_r <= NUM_BEATS'(1) << beat_idx;
        end else begin
            beat_led_r <= '0;
        end
    end

    assign beat_led = beat_led_r;
`endif

    assign notes_out    = notes_out_r;
    assign pattern_view = pattern_view_r;
    assign tempo_sel    = tempo_r;

endmodule
